// File: rtl/rvv_backend_alu_issue_if.sv
// ALU issue stage bundle: RS head, ALU lanes, ROB retire, flush and stall count.
// master = issue stage, slave = surrounding RS/ALU/ROB environment.
interface rvv_backend_alu_issue_if #(
    parameter int NUM_LANE = 2,
    parameter int UOP_W    = 256,
    parameter int RES_W    = 160,
    parameter int CNT_W    = 32
);
    localparam int VCW = $clog2(NUM_LANE + 1);

    logic [VCW-1:0]            rs_valid_cnt;
    logic [NUM_LANE*UOP_W-1:0] alu_uop_rs2ex;
    logic [NUM_LANE-1:0]       pop_ex2rs;
    logic [NUM_LANE-1:0]       lane_en;
    logic [NUM_LANE-1:0]       ex_uop_valid;
    logic [NUM_LANE*UOP_W-1:0] ex_uop;
    logic [NUM_LANE-1:0]       ex_ready;
    logic [NUM_LANE*RES_W-1:0] ex_result;
    logic [NUM_LANE-1:0]       result_valid_ex2rob;
    logic [NUM_LANE*RES_W-1:0] result_ex2rob;
    logic [NUM_LANE-1:0]       result_ready_rob2alu;
    logic                      trap_flush_rvv;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        input  rs_valid_cnt, alu_uop_rs2ex, lane_en, ex_ready, ex_result,
        input  result_ready_rob2alu, trap_flush_rvv,
        output pop_ex2rs, ex_uop_valid, ex_uop, result_valid_ex2rob,
        output result_ex2rob, stall_cnt
    );

    modport slave (
        output rs_valid_cnt, alu_uop_rs2ex, lane_en, ex_ready, ex_result,
        output result_ready_rob2alu, trap_flush_rvv,
        input  pop_ex2rs, ex_uop_valid, ex_uop, result_valid_ex2rob,
        input  result_ex2rob, stall_cnt
    );
endinterface

// File: rtl/rvv_backend_alu_issue.sv
// In-order prefix issue from the ALU RS to NUM_LANE lanes, with a small
// per-lane result FIFO toward the ROB, trap flush and a saturating stall counter.
module rvv_backend_alu_issue #(
    parameter int NUM_LANE  = 2,
    parameter int UOP_W     = 256,
    parameter int RES_W     = 160,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    rvv_backend_alu_issue_if.master io
);
    localparam int VCW = $clog2(NUM_LANE + 1);
    localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW  = $clog2(BUF_DEPTH + 1);

    logic [RES_W-1:0]    r_buf [NUM_LANE][BUF_DEPTH];
    logic [PW-1:0]       r_wp  [NUM_LANE];
    logic [PW-1:0]       r_rp  [NUM_LANE];
    logic [CW-1:0]       r_cnt [NUM_LANE];
    logic [CNT_W-1:0]    r_stall;

    logic [NUM_LANE-1:0] w_vld;
    logic [NUM_LANE-1:0] w_rv;
    logic [NUM_LANE-1:0] w_deq;
    logic [NUM_LANE-1:0] w_space;
    logic [NUM_LANE-1:0] w_go;
    logic [NUM_LANE-1:0] w_pop;
    logic                w_stall_inc;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Valid/go per lane; pop is the running AND so issue stays an in-order prefix.
    always_comb begin
        w_vld   = '0;
        w_rv    = '0;
        w_deq   = '0;
        w_space = '0;
        w_go    = '0;
        w_pop   = '0;
        for (int k = 0; k < NUM_LANE; k++) begin
            w_vld[k]   = rst_n && (VCW'(k) < io.rs_valid_cnt) &&
                         io.lane_en[k] && !io.trap_flush_rvv;
            w_rv[k]    = (r_cnt[k] != '0);
            w_deq[k]   = w_rv[k] && io.result_ready_rob2alu[k];
            w_space[k] = (r_cnt[k] < CW'(BUF_DEPTH)) || w_deq[k];
            w_go[k]    = w_vld[k] && io.ex_ready[k] && w_space[k];
        end
        w_pop[0] = w_go[0];
        for (int k = 1; k < NUM_LANE; k++)
            w_pop[k] = w_pop[k-1] && w_go[k];
    end

    assign w_stall_inc = rst_n && (io.rs_valid_cnt != '0) && !w_pop[0] &&
                         !io.trap_flush_rvv && (r_stall != '1);

    assign io.pop_ex2rs           = w_pop;
    assign io.ex_uop_valid        = w_vld;
    assign io.ex_uop              = io.alu_uop_rs2ex;
    assign io.result_valid_ex2rob = w_rv;
    assign io.stall_cnt           = r_stall;

    always_comb begin
        io.result_ex2rob = '0;
        for (int k = 0; k < NUM_LANE; k++)
            io.result_ex2rob[k*RES_W +: RES_W] = r_buf[k][r_rp[k]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LANE; k++) begin
                r_wp[k]  <= '0;
                r_rp[k]  <= '0;
                r_cnt[k] <= '0;
            end
            r_stall <= '0;
        end else begin
            for (int k = 0; k < NUM_LANE; k++) begin
                if (io.trap_flush_rvv) begin
                    r_wp[k]  <= '0;
                    r_rp[k]  <= '0;
                    r_cnt[k] <= '0;
                end else begin
                    if (w_pop[k]) r_wp[k] <= f_inc(r_wp[k]);
                    if (w_deq[k]) r_rp[k] <= f_inc(r_rp[k]);
                    unique case ({w_pop[k], w_deq[k]})
                        2'b10:   r_cnt[k] <= r_cnt[k] + CW'(1);
                        2'b01:   r_cnt[k] <= r_cnt[k] - CW'(1);
                        default: r_cnt[k] <= r_cnt[k];
                    endcase
                end
            end
            if (w_stall_inc) r_stall <= r_stall + CNT_W'(1);
        end
    end

    // Payload storage needs no reset; validity lives in r_cnt.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_LANE; k++)
            if (w_pop[k]) r_buf[k][r_wp[k]] <= io.ex_result[k*RES_W +: RES_W];
    end

    a_vcnt_legal: assert property (@(posedge clk) disable iff (!rst_n)
        io.rs_valid_cnt <= VCW'(NUM_LANE));

    a_pop_therm: assert property (@(posedge clk) disable iff (!rst_n)
        (w_pop & (w_pop + NUM_LANE'(1))) == '0);

    for (genvar g = 0; g < NUM_LANE; g++) begin : g_sva
        a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
            !(w_pop[g] && (r_cnt[g] == CW'(BUF_DEPTH)) && !w_deq[g]));
    end
endmodule
